// File: rtl/pwm_duty_ramp_if.sv
// Configuration handshake between the sensor controller and the PWM duty ramp.
// The master offers a (period, duty, step) setting; the slave answers with ready.
interface pwm_duty_ramp_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_duty;
    logic [WIDTH-1:0] cfg_step;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        output cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        input  cfg_step,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// PWM duty ramp: takes a new period/duty/step setting, applies the period on the
// next PWM wrap, then walks the compare value toward the target by 'step' per
// PWM period so the emitter soft-starts without glitches.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | duty_cmp holds; wraps ignored; new setting accepted
// PEND  | setting latched, waiting for a wrap to apply period_max
// RAMP  | stepping duty_cmp toward target on each wrap
module pwm_duty_ramp #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned DEFAULT_PERIOD = 1500,
    parameter int unsigned MIN_PERIOD     = 1
) (
    input  logic             clock,
    input  logic             reset,
    pwm_duty_ramp_if.slave   cfg,
    input  logic             wrap_tick,
    output logic [WIDTH-1:0] period_max,
    output logic [WIDTH-1:0] duty_cmp,
    output logic             busy,
    output logic             at_target
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RAMP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] MIN_PER    = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH:0]   ONE_W      = (WIDTH+1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_max_q, period_max_d;
    logic [WIDTH-1:0] duty_cmp_q, duty_cmp_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic             at_target_q, at_target_d;

    logic             accept;
    logic [WIDTH-1:0] req_period;
    logic [WIDTH:0]   req_period_p1;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH:0]   shadow_p1;
    logic             ramp_up;
    logic [WIDTH:0]   diff;

    assign accept = cfg.cfg_valid & cfg_ready_q;

    // Request clamping and ramp distance, computed purely from registered state and cfg inputs.
    always_comb begin
        req_period    = (cfg.cfg_period < MIN_PER) ? MIN_PER : cfg.cfg_period;
        req_period_p1 = {1'b0, req_period} + ONE_W;
        if ({1'b0, cfg.cfg_duty} < req_period_p1) begin
            req_target = cfg.cfg_duty;
        end else if (req_period_p1[WIDTH]) begin
            req_target = '1;
        end else begin
            req_target = req_period_p1[WIDTH-1:0];
        end
        shadow_p1 = {1'b0, shadow_q} + ONE_W;
        ramp_up   = (target_q >= duty_cmp_q);
        diff      = ramp_up ? ({1'b0, target_q} - {1'b0, duty_cmp_q})
                            : ({1'b0, duty_cmp_q} - {1'b0, target_q});
    end

    // Next-state logic: wrap handling for the current state first, then a new
    // setting overrides state/target so a colliding step still uses the old target.
    always_comb begin
        state_d      = state_q;
        period_max_d = period_max_q;
        duty_cmp_d   = duty_cmp_q;
        target_d     = target_q;
        step_d       = step_q;
        shadow_d     = shadow_q;

        case (state_q)
            PEND: begin
                if (wrap_tick) begin
                    period_max_d = shadow_q;
                    // shadow_p1 can only reach 2^WIDTH when duty cannot exceed it
                    if ({1'b0, duty_cmp_q} > shadow_p1) begin
                        duty_cmp_d = shadow_p1[WIDTH-1:0];
                    end
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (wrap_tick) begin
                    if ((step_q == '0) || (diff <= {1'b0, step_q})) begin
                        duty_cmp_d = target_q;
                        state_d    = IDLE;
                    end else if (ramp_up) begin
                        duty_cmp_d = duty_cmp_q + step_q;
                    end else begin
                        duty_cmp_d = duty_cmp_q - step_q;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            shadow_d = req_period;
            target_d = req_target;
            step_d   = cfg.cfg_step;
            state_d  = PEND;
        end

        cfg_ready_d = (state_d != PEND);
        busy_d      = (state_d != IDLE);
        at_target_d = (state_d == IDLE) && (duty_cmp_d == target_d);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            period_max_q <= DEF_PERIOD;
            duty_cmp_q   <= '0;
            target_q     <= '0;
            step_q       <= '0;
            shadow_q     <= DEF_PERIOD;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            period_max_q <= period_max_d;
            duty_cmp_q   <= duty_cmp_d;
            target_q     <= target_d;
            step_q       <= step_d;
            shadow_q     <= shadow_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign period_max    = period_max_q;
    assign duty_cmp      = duty_cmp_q;
    assign busy          = busy_q;
    assign at_target     = at_target_q;

endmodule
